// File: rtl/digit_inference_ctrl.sv
// Sequencer for one digit inference: clears the fully connected layer, streams
// WIDTH pixels into it, waits for its done flag and reports the signed argmax.
module digit_inference_ctrl #(
  parameter int BITS    = 24,
  parameter int WIDTH   = 784,
  parameter int HEIGHT  = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pix_valid,
  input  logic [BITS-1:0]          pix_data,
  output logic                     pix_ready,
  output logic                     fc_rst_n,
  output logic [9:0]               fc_counter,
  output logic [BITS-1:0]          fc_pixel,
  input  logic                     fc_done,
  input  logic [BITS*HEIGHT-1:0]   fc_scores,
  output logic                     busy,
  output logic                     result_valid,
  output logic [3:0]               digit,
  output logic [BITS-1:0]          max_score,
  output logic                     error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_ARGMAX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [3:0]      arg_i_q, arg_i_d;
  logic [3:0]      best_q, best_d;
  logic [BITS-1:0] run_max_q, run_max_d;
  logic            err_q, err_d;

  logic            pix_ready_q, pix_ready_d;
  logic            fc_rst_n_q, fc_rst_n_d;
  logic [9:0]      fc_counter_q, fc_counter_d;
  logic [BITS-1:0] fc_pixel_q, fc_pixel_d;
  logic            busy_q, busy_d;
  logic            result_valid_q, result_valid_d;
  logic [3:0]      digit_q, digit_d;
  logic [BITS-1:0] max_score_q, max_score_d;
  logic            error_q, error_d;

  logic            xfer;
  logic            last_pix;
  logic [BITS-1:0] cur_score;

  // Handshake uses the registered ready the source actually sees.
  assign xfer     = (state_q == S_LOAD) && pix_valid && pix_ready_q;
  assign last_pix = (idx_q == 10'(WIDTH - 1));

  always_comb begin
    cur_score = '0;
    for (int k = 0; k < HEIGHT; k++) begin
      if (arg_i_q == 4'(k)) cur_score = fc_scores[k*BITS +: BITS];
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    idx_d          = idx_q;
    tmo_d          = tmo_q;
    arg_i_d        = arg_i_q;
    best_d         = best_q;
    run_max_d      = run_max_q;
    err_d          = err_q;
    pix_ready_d    = 1'b0;
    fc_rst_n_d     = (state_q != S_CLEAR);
    fc_counter_d   = '0;
    fc_pixel_d     = fc_pixel_q;
    busy_d         = (state_q != S_IDLE);
    result_valid_d = 1'b0;
    digit_d        = digit_q;
    max_score_d    = max_score_q;
    error_d        = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end

      S_CLEAR: begin
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = S_LOAD;
      end

      S_LOAD: begin
        pix_ready_d = 1'b1;
        if (xfer) begin
          idx_d        = idx_q + 10'd1;
          fc_counter_d = idx_q + 10'd1;
          fc_pixel_d   = pix_data;
          if (last_pix) begin
            pix_ready_d = 1'b0;
            tmo_d       = '0;
            state_d     = S_COMPUTE;
          end
        end
      end

      S_COMPUTE: begin
        if (fc_done) begin
          arg_i_d = '0;
          state_d = S_ARGMAX;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_ARGMAX: begin
        // Strict greater-than keeps the lowest index on ties.
        if ((arg_i_q == 4'd0) || ($signed(cur_score) > $signed(run_max_q))) begin
          run_max_d = cur_score;
          best_d    = arg_i_q;
        end
        arg_i_d = arg_i_q + 4'd1;
        if (arg_i_q == 4'(HEIGHT - 1)) state_d = S_DONE;
      end

      S_DONE: begin
        result_valid_d = 1'b1;
        if (err_q) begin
          digit_d     = 4'hF;
          max_score_d = '0;
          error_d     = 1'b1;
        end else begin
          digit_d     = best_q;
          max_score_d = run_max_q;
          error_d     = 1'b0;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      tmo_q          <= '0;
      arg_i_q        <= '0;
      best_q         <= '0;
      run_max_q      <= '0;
      err_q          <= 1'b0;
      pix_ready_q    <= 1'b0;
      fc_rst_n_q     <= 1'b0;
      fc_counter_q   <= '0;
      fc_pixel_q     <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      digit_q        <= '0;
      max_score_q    <= '0;
      error_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q        <= state_d;
      idx_q          <= idx_d;
      tmo_q          <= tmo_d;
      arg_i_q        <= arg_i_d;
      best_q         <= best_d;
      run_max_q      <= run_max_d;
      err_q          <= err_d;
      pix_ready_q    <= pix_ready_d;
      fc_rst_n_q     <= fc_rst_n_d;
      fc_counter_q   <= fc_counter_d;
      fc_pixel_q     <= fc_pixel_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      digit_q        <= digit_d;
      max_score_q    <= max_score_d;
      error_q        <= error_d;
    end
  end

  assign pix_ready    = pix_ready_q;
  assign fc_rst_n     = fc_rst_n_q;
  assign fc_counter   = fc_counter_q;
  assign fc_pixel     = fc_pixel_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign digit        = digit_q;
  assign max_score    = max_score_q;
  assign error        = error_q;

endmodule

// File: tb/tb_digit_inference_ctrl.sv
// Directed bench for digit_inference_ctrl: pixel and result scoreboards fed as
// stimulus is driven, drained as the controller produces fc_counter/result_valid.
module tb_digit_inference_ctrl;

  localparam int BITS    = 24;
  localparam int WIDTH   = 784;
  localparam int HEIGHT  = 10;
  localparam int TIMEOUT = 1023;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic                   pix_valid = 1'b0;
  logic [BITS-1:0]        pix_data = '0;
  logic                   fc_done = 1'b0;
  logic [BITS*HEIGHT-1:0] fc_scores = '0;
  logic                   pix_ready, fc_rst_n, busy, result_valid, error;
  logic [9:0]             fc_counter;
  logic [BITS-1:0]        fc_pixel, max_score;
  logic [3:0]             digit;

  always #5 clk = ~clk;

  digit_inference_ctrl #(
    .BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .fc_rst_n(fc_rst_n), .fc_counter(fc_counter), .fc_pixel(fc_pixel),
    .fc_done(fc_done), .fc_scores(fc_scores),
    .busy(busy), .result_valid(result_valid), .digit(digit),
    .max_score(max_score), .error(error)
  );

  typedef struct packed {
    logic [9:0]      idx;
    logic [BITS-1:0] data;
  } pix_t;

  typedef struct packed {
    logic [3:0]      digit;
    logic [BITS-1:0] max;
    logic            err;
  } res_t;

  pix_t                   pix_q[$];
  res_t                   res_q[$];
  res_t                   last_exp = '0;
  logic [BITS-1:0]        last_data = '0;
  logic signed [BITS-1:0] sc [HEIGHT];
  int                     n_tests = 0;
  int                     n_fail = 0;
  int                     n_results = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge and fed to the scoreboards.
  task automatic tick();
    pix_t p;
    res_t r;
    @(posedge clk);
    #1;
    if (fc_counter != '0) begin
      check("pix_sb_nonempty", 64'(pix_q.size() > 0), 64'(1));
      if (pix_q.size() > 0) begin
        p = pix_q.pop_front();
        check("sb_fc_counter", 64'(fc_counter), 64'(p.idx));
        check("sb_fc_pixel", 64'(fc_pixel), 64'(p.data));
      end
    end
    if (result_valid) begin
      n_results++;
      check("res_sb_nonempty", 64'(res_q.size() > 0), 64'(1));
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        check("sb_digit", 64'(digit), 64'(r.digit));
        check("sb_max_score", 64'(max_score), 64'(r.max));
        check("sb_error", 64'(error), 64'(r.err));
      end
    end
  endtask

  function automatic res_t argmax_model();
    res_t r;
    logic signed [BITS-1:0] best;
    best    = sc[0];
    r.digit = 4'd0;
    for (int i = 1; i < HEIGHT; i++) begin
      if (sc[i] > best) begin
        best    = sc[i];
        r.digit = 4'(i);
      end
    end
    r.max = best;
    r.err = 1'b0;
    return r;
  endfunction

  task automatic apply_scores();
    for (int i = 0; i < HEIGHT; i++) fc_scores[i*BITS +: BITS] = sc[i];
  endtask

  task automatic do_start(input logic hold);
    start = 1'b1;
    tick();
    start = hold;
    check("busy_edge0", 64'(busy), 64'(0));
    tick();
    check("busy_edge1", 64'(busy), 64'(1));
    check("fc_rst_n_clear", 64'(fc_rst_n), 64'(0));
    check("pix_ready_edge1", 64'(pix_ready), 64'(0));
    tick();
    check("fc_rst_n_release", 64'(fc_rst_n), 64'(1));
    check("pix_ready_edge2", 64'(pix_ready), 64'(1));
  endtask

  // start_at >= 0 pulses start while pixel start_at is pending; -1 leaves start alone.
  task automatic load(input logic gapped, input int npix, input int start_at);
    int   cnt = 0;
    int   budget = 0;
    logic v = 1'b1;
    logic xf;
    pix_t p;
    while (cnt < npix && budget < 4 * WIDTH) begin
      pix_valid = v;
      pix_data  = BITS'($urandom);
      if (start_at >= 0) start = (cnt == start_at);
      xf = v && pix_ready;
      if (xf) begin
        cnt++;
        p.idx  = 10'(cnt);
        p.data = pix_data;
        pix_q.push_back(p);
        last_data = pix_data;
      end
      tick();
      budget++;
      if (xf) begin
        check("fc_counter_walk", 64'(fc_counter), 64'(cnt));
      end else begin
        check("fc_counter_gap", 64'(fc_counter), 64'(0));
        check("fc_pixel_hold", 64'(fc_pixel), 64'(last_data));
      end
      if (gapped) v = ~v;
    end
    pix_valid = 1'b0;
    if (start_at >= 0) start = 1'b0;
    check("pixels_accepted", 64'(cnt), 64'(npix));
    if (npix == WIDTH) check("pix_ready_drop", 64'(pix_ready), 64'(0));
  endtask

  // Ends on the tick that shows result_valid.
  task automatic compute(input int delay, input logic timeout_case, input logic pulse_start);
    int   r0 = n_results;
    res_t e;
    if (timeout_case) begin
      e.digit = 4'hF;
      e.max   = '0;
      e.err   = 1'b1;
      res_q.push_back(e);
      last_exp = e;
      for (int i = 0; i < TIMEOUT; i++) tick();
    end else begin
      apply_scores();
      e = argmax_model();
      res_q.push_back(e);
      last_exp = e;
      for (int i = 0; i < delay; i++) begin
        if (pulse_start) start = (i == 2);
        tick();
      end
      if (pulse_start) start = 1'b0;
      fc_done = 1'b1;
      tick();
      for (int i = 0; i < HEIGHT; i++) tick();
    end
    check("no_early_result", 64'(n_results - r0), 64'(0));
    tick();
    check("result_valid_timing", 64'(result_valid), 64'(1));
    check("busy_at_result", 64'(busy), 64'(1));
    check("one_result", 64'(n_results - r0), 64'(1));
    fc_done = 1'b0;
  endtask

  task automatic finish_idle();
    tick();
    check("result_valid_pulse", 64'(result_valid), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    tick();
    tick();
    check("busy_stays_idle", 64'(busy), 64'(0));
    check("digit_hold", 64'(digit), 64'(last_exp.digit));
    check("max_score_hold", 64'(max_score), 64'(last_exp.max));
    check("error_hold", 64'(error), 64'(last_exp.err));
    check("pix_sb_drained", 64'(pix_q.size()), 64'(0));
  endtask

  task automatic check_reset_values();
    check("rst_pix_ready", 64'(pix_ready), 64'(0));
    check("rst_fc_rst_n", 64'(fc_rst_n), 64'(0));
    check("rst_fc_counter", 64'(fc_counter), 64'(0));
    check("rst_fc_pixel", 64'(fc_pixel), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_result_valid", 64'(result_valid), 64'(0));
    check("rst_digit", 64'(digit), 64'(0));
    check("rst_max_score", 64'(max_score), 64'(0));
    check("rst_error", 64'(error), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Power-on reset
    #2;
    check_reset_values();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("fc_rst_n_after_reset", 64'(fc_rst_n), 64'(1));
    check("busy_after_reset", 64'(busy), 64'(0));

    // Nominal: back-to-back pixels, fc_done 784 cycles after COMPUTE entry
    sc[0] = 24'sh000100;
    sc[1] = -24'sd5;
    sc[2] = 24'sh001000;
    for (int i = 3; i < 9; i++) sc[i] = BITS'(24'h000200 + i);
    sc[9] = 24'sh000800;
    do_start(1'b0);
    load(1'b0, WIDTH, -1);
    compute(784, 1'b0, 1'b0);
    check("nominal_digit", 64'(digit), 64'(2));
    check("nominal_max", 64'(max_score), 64'(24'h001000));
    finish_idle();

    // Gapped input; fc_done already high during LOAD must be ignored until COMPUTE
    for (int i = 0; i < HEIGHT; i++) sc[i] = BITS'(24'h000100 * i);
    sc[7] = 24'sh005000;
    fc_done = 1'b1;
    do_start(1'b0);
    load(1'b1, WIDTH, -1);
    compute(0, 1'b0, 1'b0);
    finish_idle();

    // All scores equal and negative: lowest index wins
    for (int i = 0; i < HEIGHT; i++) sc[i] = -24'sd100;
    do_start(1'b0);
    load(1'b0, WIDTH, -1);
    compute(3, 1'b0, 1'b0);
    check("tie_neg_digit", 64'(digit), 64'(0));
    check("tie_neg_max", 64'(max_score), 64'(24'hFFFF9C));
    finish_idle();

    // Tie at the positive maximum between digits 3 and 7
    sc[3] = 24'sh7FFFFF;
    sc[7] = 24'sh7FFFFF;
    do_start(1'b0);
    load(1'b0, WIDTH, -1);
    compute(3, 1'b0, 1'b0);
    check("tie_max_digit", 64'(digit), 64'(3));
    finish_idle();

    // Timeout: fc_done never arrives
    do_start(1'b0);
    load(1'b0, WIDTH, -1);
    compute(0, 1'b1, 1'b0);
    check("timeout_digit", 64'(digit), 64'(4'hF));
    check("timeout_error", 64'(error), 64'(1));
    finish_idle();

    // Asynchronous reset after 300 pixels, then a clean full inference
    do_start(1'b0);
    load(1'b0, 300, -1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values();
    pix_q.delete();
    last_data = '0;
    last_exp  = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("fc_rst_n_after_midreset", 64'(fc_rst_n), 64'(1));
    for (int i = 0; i < HEIGHT; i++) sc[i] = BITS'(24'h000010 * i);
    do_start(1'b0);
    load(1'b0, WIDTH, -1);
    compute(4, 1'b0, 1'b0);
    check("post_reset_digit", 64'(digit), 64'(9));
    finish_idle();

    // Start pulses during LOAD and COMPUTE are ignored
    sc[4] = 24'sh000400;
    do_start(1'b0);
    load(1'b0, WIDTH, 100);
    compute(10, 1'b0, 1'b1);
    finish_idle();

    // Start held high: two back-to-back inferences, each with its own CLEAR pulse
    sc[1] = 24'sh010000;
    do_start(1'b1);
    load(1'b0, WIDTH, -1);
    compute(2, 1'b0, 1'b0);
    sc[1] = -24'sd1;
    sc[6] = 24'sh020000;
    do_start(1'b1);
    load(1'b0, WIDTH, -1);
    compute(2, 1'b0, 1'b0);
    check("held_second_digit", 64'(digit), 64'(6));
    start = 1'b0;
    finish_idle();
    check("res_sb_drained", 64'(res_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
